// File: rtl/stream_demux2.sv
// Registered 1-to-2 stream demultiplexer: a per-beat select steers each input beat
// into one of two independently back-pressured 2-entry output buffers with handshake counters.

// state | meaning
// EMPTY | no beat buffered, output invalid
// ONE   | head holds one beat
// FULL  | head and tail both hold beats, push blocked
module stream_demux2_chan #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic [CNT_W-1:0] o_count
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

   occ_e             state_q, state_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic [WIDTH-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      cnt_d   = cnt_q;
      pop     = (state_q != EMPTY) && i_ready;
      case (state_q)
         EMPTY: begin
            if (i_push) begin
               state_d = ONE;
               head_d  = i_data;
            end
         end
         ONE: begin
            // simultaneous push and pop replaces the head in place
            if (i_push && pop) begin
               head_d = i_data;
            end else if (i_push) begin
               state_d = FULL;
               tail_d  = i_data;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (pop) cnt_d = cnt_q + CNT_W'(1);
   end

   assign o_valid = (state_q != EMPTY);
   assign o_data  = head_q;
   assign o_full  = (state_q == FULL);
   assign o_count = cnt_q;
endmodule

module stream_demux2 #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_sel,
   output logic             o_a_valid,
   input  logic             i_a_ready,
   output logic [WIDTH-1:0] o_a_data,
   output logic             o_b_valid,
   input  logic             i_b_ready,
   output logic [WIDTH-1:0] o_b_data,
   output logic [CNT_W-1:0] o_a_count,
   output logic [CNT_W-1:0] o_b_count,
   output logic             o_busy
);
   logic a_full, b_full;
   logic accept;

   // readiness looks only at registered occupancy, never at the sinks
   assign o_ready = i_rst_n && !(i_sel ? b_full : a_full);
   assign accept  = i_valid && o_ready;

   stream_demux2_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (accept && !i_sel),
      .i_data  (i_data),
      .i_ready (i_a_ready),
      .o_valid (o_a_valid),
      .o_data  (o_a_data),
      .o_full  (a_full),
      .o_count (o_a_count)
   );

   stream_demux2_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (accept && i_sel),
      .i_data  (i_data),
      .i_ready (i_b_ready),
      .o_valid (o_b_valid),
      .o_data  (o_b_data),
      .o_full  (b_full),
      .o_count (o_b_count)
   );

   assign o_busy = o_a_valid || o_b_valid;
endmodule

// File: tb/tb_stream_demux2.sv
// Directed bench for stream_demux2: vector table for streaming and back-pressure,
// hand sequences for counter wrap and asynchronous reset.
module tb_stream_demux2;
   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;
   logic             sel;
   logic             a_valid, b_valid;
   logic             a_rdy, b_rdy;
   logic [WIDTH-1:0] a_data, b_data;
   logic [CNT_W-1:0] a_cnt, b_cnt;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   stream_demux2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (valid),
      .o_ready   (ready),
      .i_data    (data),
      .i_sel     (sel),
      .o_a_valid (a_valid),
      .i_a_ready (a_rdy),
      .o_a_data  (a_data),
      .o_b_valid (b_valid),
      .i_b_ready (b_rdy),
      .o_b_data  (b_data),
      .o_a_count (a_cnt),
      .o_b_count (b_cnt),
      .o_busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic       s;
      logic [7:0] d;
      logic       ar;
      logic       br;
      logic       r;
      logic       av;
      logic [7:0] ad;
      logic       bv;
      logic [7:0] bd;
      logic [3:0] ac;
      logic [3:0] bc;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];

   function automatic vec_t mk(logic v, logic s, logic [7:0] d, logic ar, logic br,
                               logic r, logic av, logic [7:0] ad, logic bv, logic [7:0] bd,
                               logic [3:0] ac, logic [3:0] bc);
      vec_t t;
      t.v = v; t.s = s; t.d = d; t.ar = ar; t.br = br;
      t.r = r; t.av = av; t.ad = ad; t.bv = bv; t.bd = bd; t.ac = ac; t.bc = bc;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      //            v  s  d      ar br | r  av ad     bv bd     ac bc
      // alternating A/B, sinks always ready
      vecs[0]  = mk(1, 0, 8'h11, 1, 1,   1, 0, 8'h00, 0, 8'h00, 0, 0);
      vecs[1]  = mk(1, 1, 8'h22, 1, 1,   1, 1, 8'h11, 0, 8'h00, 0, 0);
      vecs[2]  = mk(1, 0, 8'h33, 1, 1,   1, 0, 8'h00, 1, 8'h22, 1, 0);
      vecs[3]  = mk(1, 1, 8'h44, 1, 1,   1, 1, 8'h33, 0, 8'h00, 1, 1);
      vecs[4]  = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'h00, 1, 8'h44, 2, 1);
      vecs[5]  = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'h00, 0, 8'h00, 2, 2);
      // back-pressure on A, B keeps flowing, then FULL with same-cycle pop
      vecs[6]  = mk(1, 0, 8'hA0, 0, 1,   1, 0, 8'h00, 0, 8'h00, 2, 2);
      vecs[7]  = mk(1, 0, 8'hA1, 0, 1,   1, 1, 8'hA0, 0, 8'h00, 2, 2);
      vecs[8]  = mk(1, 0, 8'hA2, 0, 1,   0, 1, 8'hA0, 0, 8'h00, 2, 2);
      vecs[9]  = mk(1, 1, 8'hB0, 0, 1,   1, 1, 8'hA0, 0, 8'h00, 2, 2);
      vecs[10] = mk(1, 0, 8'hA2, 0, 1,   0, 1, 8'hA0, 1, 8'hB0, 2, 2);
      vecs[11] = mk(1, 0, 8'hA2, 1, 1,   0, 1, 8'hA0, 0, 8'h00, 2, 3);
      vecs[12] = mk(1, 0, 8'hA2, 1, 1,   1, 1, 8'hA1, 0, 8'h00, 3, 3);
      vecs[13] = mk(0, 0, 8'h00, 1, 1,   1, 1, 8'hA2, 0, 8'h00, 4, 3);
      vecs[14] = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'h00, 0, 8'h00, 5, 3);
      // full-rate single-output streaming
      vecs[15] = mk(1, 0, 8'h51, 1, 1,   1, 0, 8'h00, 0, 8'h00, 5, 3);
      vecs[16] = mk(1, 0, 8'h52, 1, 1,   1, 1, 8'h51, 0, 8'h00, 5, 3);
      vecs[17] = mk(1, 0, 8'h53, 1, 1,   1, 1, 8'h52, 0, 8'h00, 6, 3);
      vecs[18] = mk(0, 0, 8'h00, 1, 1,   1, 1, 8'h53, 0, 8'h00, 7, 3);
      vecs[19] = mk(0, 0, 8'h00, 1, 1,   1, 0, 8'h00, 0, 8'h00, 8, 3);

      // reset with a beat offered
      rst_n = 1'b0; valid = 1'b1; sel = 1'b0; data = 8'hFF; a_rdy = 1'b1; b_rdy = 1'b1;
      #3;
      chk("rst_ready", ready, 0);
      chk("rst_a_valid", a_valid, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_a_data", a_data, 0);
      chk("rst_b_data", b_data, 0);
      chk("rst_a_count", a_cnt, 0);
      chk("rst_b_count", b_cnt, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #3;
      chk("rst_edge_ready", ready, 0);
      chk("rst_edge_a_valid", a_valid, 0);
      chk("rst_edge_busy", busy, 0);

      // release; the release cycle is the first table row
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < NV; i++) begin
         valid = vecs[i].v; sel = vecs[i].s; data = vecs[i].d;
         a_rdy = vecs[i].ar; b_rdy = vecs[i].br;
         #1;
         chk($sformatf("v%0d_ready", i), ready, vecs[i].r);
         chk($sformatf("v%0d_a_valid", i), a_valid, vecs[i].av);
         chk($sformatf("v%0d_b_valid", i), b_valid, vecs[i].bv);
         chk($sformatf("v%0d_busy", i), busy, vecs[i].av | vecs[i].bv);
         chk($sformatf("v%0d_a_count", i), a_cnt, vecs[i].ac);
         chk($sformatf("v%0d_b_count", i), b_cnt, vecs[i].bc);
         if (vecs[i].av) chk($sformatf("v%0d_a_data", i), a_data, vecs[i].ad);
         if (vecs[i].bv) chk($sformatf("v%0d_b_data", i), b_data, vecs[i].bd);
         next_cycle();
      end

      // counter wrap: 17 A handshakes on a 4-bit counter
      valid = 1'b0;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      a_rdy = 1'b1; b_rdy = 1'b1; sel = 1'b0;
      for (int i = 0; i < 19; i++) begin
         int pops;
         valid = (i < 17);
         data  = 8'(i);
         pops  = (i == 0) ? 0 : i - 1;
         #1;
         chk($sformatf("wrap%0d_a_count", i), a_cnt, 32'(pops % 16));
         if (i >= 1 && i <= 17) begin
            chk($sformatf("wrap%0d_a_valid", i), a_valid, 1);
            chk($sformatf("wrap%0d_a_data", i), a_data, 32'(i - 1));
         end
         next_cycle();
      end
      chk("wrap_end_a_valid", a_valid, 0);

      // fill both outputs, then reset asynchronously between edges
      a_rdy = 1'b0; b_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1;
         sel   = (i >= 2);
         data  = (i < 2) ? 8'(8'hC0 + i) : 8'(8'hD0 + i - 2);
         #1;
         chk($sformatf("fill%0d_ready", i), ready, 1);
         next_cycle();
      end
      sel = 1'b0;
      #1;
      chk("full_a_ready", ready, 0);
      sel = 1'b1;
      #1;
      chk("full_b_ready", ready, 0);
      chk("full_a_data", a_data, 8'hC0);
      chk("full_b_data", b_data, 8'hD0);
      chk("full_busy", busy, 1);
      chk("full_a_count", a_cnt, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_a_valid", a_valid, 0);
      chk("arst_b_valid", b_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_a_count", a_cnt, 0);
      chk("arst_ready", ready, 0);
      chk("arst_a_data", a_data, 0);
      valid = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      a_rdy = 1'b1; b_rdy = 1'b1;
      #1;
      chk("rel_ready", ready, 1);
      chk("rel_a_valid", a_valid, 0);
      chk("rel_b_valid", b_valid, 0);
      next_cycle();
      #1;
      chk("post_a_valid", a_valid, 0);
      chk("post_b_valid", b_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_a_count", a_cnt, 0);
      chk("post_b_count", b_cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/stream_demux2.md
# stream_demux2

Registered 1-to-2 stream demultiplexer. It is the return-direction companion of the 8-bit 2:1 select datapath. One valid/ready input stream is steered by a per-beat select bit into one of two independently back-pressured output streams. Each output has a 2-entry buffer and a transfer counter, so a stalled output never blocks beats destined for the other output once they are buffered.

## Interface
- WIDTH, 8, data width of input and both outputs
- CNT_W, 16, width of per-output transfer counters
- i_clk  input  1  single clock; all state on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_valid  input  1  input beat valid
- o_ready  output  1  input beat accepted when i_valid && o_ready
- i_data  input  WIDTH  input beat payload
- i_sel  input  1  destination of current beat: 0 -> A, 1 -> B; qualified by i_valid
- o_a_valid  output  1  output A beat valid
- i_a_ready  input  1  output A sink ready
- o_a_data  output  WIDTH  output A payload
- o_b_valid  output  1  output B beat valid
- i_b_ready  input  1  output B sink ready
- o_b_data  output  WIDTH  output B payload
- o_a_count  output  CNT_W  completed A handshakes, modulo 2^CNT_W
- o_b_count  output  CNT_W  completed B handshakes, modulo 2^CNT_W
- o_busy  output  1  high when either buffer holds at least one entry

## Operation
- Each output X (A or B) has a 2-entry FIFO with an occupancy state machine: EMPTY, ONE, FULL.
- Push_X = i_valid && o_ready && (i_sel selects X).
- Pop_X = o_X_valid && i_X_ready.
- Transitions:
  - EMPTY: push -> ONE.
  - ONE: push && !pop -> FULL; pop && !push -> EMPTY; push && pop -> ONE, with the new beat becoming head.
  - FULL: pop -> ONE. No push can occur in FULL.
- o_ready = !FULL[i_sel], evaluated combinationally from i_sel and registered state only. It does not depend on i_valid or on i_X_ready, so a same-cycle pop does not free a FULL slot for a push.
- o_ready is forced 0 while i_rst_n is low.
- o_X_valid = state != EMPTY. o_X_data = head entry, driven from registers with no combinational path from i_data.
- Ordering: order is preserved per output. There is no ordering relation between A and B.
- Counters: o_X_count increments by 1 on each Pop_X and wraps from 2^CNT_W-1 to 0.
- o_busy = (A != EMPTY) || (B != EMPTY).
- Data entries that are not valid are don't-care internally, but output data reads 0 after reset until the first push.

## Timing
- Reset values: o_a_valid = o_b_valid = 0; o_a_data = o_b_data = 0; o_a_count = o_b_count = 0; o_busy = 0; o_ready = 0 during reset, 1 the first cycle after release.
- Reset mid-operation discards all buffered beats immediately, without waiting for a clock edge. Beats presented in the reset-release cycle are accepted normally.
- Latency: a beat accepted at edge N is visible on o_X_valid/o_X_data after edge N (one cycle). The earliest pop is at edge N+1.
- Throughput: one beat per cycle per output with an always-ready sink, including alternating A/B selection.
- Full-rate single-output streaming with i_X_ready held 1 keeps the state at ONE and never deasserts o_ready.
- With i_X_ready = 0, two beats fill X. o_ready then drops for beats selecting X while remaining 1 for beats selecting the other output.
- A change of i_sel while i_valid is high and o_ready is low is legal. The beat targets whatever i_sel is in the accepting cycle.
- Counters update at the edge of the handshake and are visible the following cycle.

## Test plan
- Reset then idle: hold i_rst_n = 0 with i_valid = 1 -> o_ready = 0, all valids and counts 0. Release -> o_ready = 1 next cycle.
- Alternating stream: send 0x11(A), 0x22(B), 0x33(A), 0x44(B) back-to-back, sinks always ready -> A emits 0x11, 0x33 and B emits 0x22, 0x44, each one cycle after acceptance. No stall; o_a_count = o_b_count = 2.
- Back-pressure isolation: i_a_ready = 0, send 0xA0, 0xA1, 0xA2 to A -> the first two accepted, o_ready = 0 on the third. Switch i_sel to B with 0xB0 -> accepted and emitted on B. Raise i_a_ready -> 0xA0, 0xA1, 0xA2 emerge in order.
- FULL with same-cycle pop: A FULL, i_a_ready = 1, i_valid = 1 with i_sel = 0 -> o_ready = 0 that cycle, the beat is accepted the next cycle, and no beat is lost or duplicated.
- Counter wrap (CNT_W = 4): 17 A handshakes -> o_a_count reads 15, then 0, then 1.
- Mid-operation reset: both buffers FULL, pulse i_rst_n low asynchronously -> valids, counts, o_busy drop to 0 without a clock edge. No stale beat appears after release.
